// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-button operand entry FSM with synchronizers, debouncers and registered outputs
module operand_loader #(
  parameter int          DEB_WIDTH = 17,
  parameter int unsigned DEB_LIMIT = 120000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       op_sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic       out_op,
  output logic       ready,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RDY = 2'b10
  } state_t;

  localparam logic [DEB_WIDTH-1:0] LIM_M1  = DEB_WIDTH'(DEB_LIMIT - 1);
  localparam logic [DEB_WIDTH-1:0] CNT_MAX = '1;

  // Index 0 is the load button, index 1 is the clear button.
  logic [3:0]           r_sw_s1, r_sw_s2;
  logic                 r_op_s1, r_op_s2;
  logic [1:0]           r_btn_s1, r_btn_s2;
  logic [1:0]           r_deb, r_deb_q, r_pulse;
  logic [DEB_WIDTH-1:0] r_cnt [2];

  state_t     r_state, w_state_nxt;
  logic [3:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic       r_op, r_ready, w_op_nxt, w_ready_nxt;
  logic       w_load_p, w_clr_p;

  assign w_load_p = r_pulse[0];
  assign w_clr_p  = r_pulse[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_op_s1  <= 1'b0;
      r_op_s2  <= 1'b0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_op_s1  <= op_sw;
      r_op_s2  <= r_op_s1;
      r_btn_s1 <= {btn_clr, btn_load};
      r_btn_s2 <= r_btn_s1;
    end
  end

  // A level is accepted only after DEB_LIMIT consecutive mismatching samples.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= '0;
      r_deb_q <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= LIM_M1) begin
          r_deb[i] <= r_btn_s2[i];
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_deb_q <= r_deb;
      r_pulse <= r_deb & ~r_deb_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_A;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_p) begin
      w_state_nxt = S_A;
    end else begin
      case (r_state)
        S_A:     if (w_load_p) w_state_nxt = S_B;
        S_B:     if (w_load_p) w_state_nxt = S_RDY;
        S_RDY:   w_state_nxt = S_RDY;
        default: w_state_nxt = S_A;
      endcase
    end
  end

  always_comb begin
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_ready_nxt = r_ready;
    if (w_clr_p) begin
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = 1'b0;
      w_ready_nxt = 1'b0;
    end else if (w_load_p) begin
      case (r_state)
        S_A: w_a_nxt = r_sw_s2;
        S_B: begin
          w_b_nxt     = r_sw_s2;
          w_op_nxt    = r_op_s2;
          w_ready_nxt = 1'b1;
        end
        S_RDY:   w_op_nxt = r_op_s2;
        default: w_ready_nxt = r_ready;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign out_a  = r_a;
  assign out_b  = r_b;
  assign out_op = r_op;
  assign ready  = r_ready;
  assign phase  = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed and random stimulus for operand_loader against a window-based model
module tb_operand_loader;

  localparam int L = 4;
  localparam int N = 4096;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sw, btn_load, btn_clr;
  logic [3:0] out_a, out_b;
  logic       out_op, ready;
  logic [1:0] phase;

  operand_loader #(.DEB_WIDTH(17), .DEB_LIMIT(L)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sw(sw), .op_sw(op_sw),
    .btn_load(btn_load), .btn_clr(btn_clr),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .ready(ready), .phase(phase)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd = 0;

  // Model: raw samples per edge; a button level flips once L consecutive synced samples disagree.
  logic       h_ld [N], h_cl [N], h_op [N], rise_ld [N], rise_cl [N];
  logic [3:0] h_sw [N];
  int         e;
  logic       m_deb_ld, m_deb_cl, m_op, m_ready;
  logic [3:0] m_a, m_b;
  logic [1:0] m_phase;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      h_ld[i] = 0; h_cl[i] = 0; h_op[i] = 0; h_sw[i] = 0; rise_ld[i] = 0; rise_cl[i] = 0;
    end
    e = 0; m_deb_ld = 0; m_deb_cl = 0;
    m_a = 0; m_b = 0; m_op = 0; m_ready = 0; m_phase = 0;
  endtask

  function automatic logic flips(input logic is_clr, input int idx, input logic deb);
    for (int k = 0; k < L; k++) begin
      int  j;
      logic v;
      j = idx - 2 - k;
      v = (j < 0) ? 1'b0 : (is_clr ? h_cl[j] : h_ld[j]);
      if (v == deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    logic ld_p, cl_p;
    h_ld[e] = btn_load; h_cl[e] = btn_clr; h_sw[e] = sw; h_op[e] = op_sw;
    ld_p = (e >= 2) ? rise_ld[e-2] : 1'b0;
    cl_p = (e >= 2) ? rise_cl[e-2] : 1'b0;
    if (cl_p) begin
      m_a = 0; m_b = 0; m_op = 0; m_ready = 0; m_phase = 0;
    end else if (ld_p) begin
      if (m_phase == 0) begin
        m_a = h_sw[e-2]; m_phase = 1;
      end else if (m_phase == 1) begin
        m_b = h_sw[e-2]; m_op = h_op[e-2]; m_ready = 1; m_phase = 2;
      end else begin
        m_op = h_op[e-2];
      end
    end
    rise_ld[e] = 0;
    rise_cl[e] = 0;
    if (flips(0, e, m_deb_ld)) begin rise_ld[e] = !m_deb_ld; m_deb_ld = !m_deb_ld; end
    if (flips(1, e, m_deb_cl)) begin rise_cl[e] = !m_deb_cl; m_deb_cl = !m_deb_cl; end
    e++;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_a", {4'd0, out_a}, {4'd0, m_a});
    chk("out_b", {4'd0, out_b}, {4'd0, m_b});
    chk("out_op", {7'd0, out_op}, {7'd0, m_op});
    chk("ready", {7'd0, ready}, {7'd0, m_ready});
    chk("phase", {6'd0, phase}, {6'd0, m_phase});
  endtask

  task automatic cyc(input logic ld, input logic cl);
    @(negedge clk_in);
    btn_load = ld;
    btn_clr  = cl;
    if (rnd) begin
      sw    = 4'($urandom_range(0, 15));
      op_sw = 1'($urandom_range(0, 1));
    end
    @(posedge clk_in);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic press(input int n);
    repeat (n) cyc(1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic op, input logic rdy, input logic [1:0] ph);
    chk({tag, "_a"}, {4'd0, out_a}, {4'd0, a});
    chk({tag, "_b"}, {4'd0, out_b}, {4'd0, b});
    chk({tag, "_op"}, {7'd0, out_op}, {7'd0, op});
    chk({tag, "_rdy"}, {7'd0, ready}, {7'd0, rdy});
    chk({tag, "_ph"}, {6'd0, phase}, {6'd0, ph});
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 0;
    #1;
    chk_all("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk_in);
    rst_n = 1;
    model_clear();
  endtask

  initial begin
    rst_n = 0; sw = 0; op_sw = 0; btn_load = 0; btn_clr = 0;
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk_in);
    rst_n = 1;
    idle(4);

    // Operand A lands exactly L+3 edges after the first high sample.
    sw = 4'd9; op_sw = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      if (i == L + 2) chk("a_early", {4'd0, out_a}, 8'd0);
      if (i == L + 3) begin
        chk("a_on_time", {4'd0, out_a}, 8'd9);
        chk("a_phase", {6'd0, phase}, 8'd1);
      end
    end
    idle(8);
    sw = 4'd5; op_sw = 1;
    press(10);
    idle(8);
    chk_all("load_b", 4'd9, 4'd5, 1'b1, 1'b1, 2'd2);

    // Short presses and a bounce train must be rejected.
    for (int len = 1; len < L; len++) begin
      op_sw = 0;
      press(len);
      idle(6);
      chk_all("short", 4'd9, 4'd5, 1'b1, 1'b1, 2'd2);
    end
    for (int i = 0; i < 6; i++) cyc(logic'(i % 2 == 0), 0);
    idle(6);
    chk_all("bounce", 4'd9, 4'd5, 1'b1, 1'b1, 2'd2);

    // In S_RDY a load only re-captures the operation.
    op_sw = 0;
    press(10);
    idle(8);
    chk_all("rdy_op", 4'd9, 4'd5, 1'b0, 1'b1, 2'd2);
    op_sw = 1;
    for (int i = 0; i < 50; i++) begin
      cyc(1, 0);
      if (i == 10) op_sw = 0;
    end
    idle(8);
    chk_all("held", 4'd9, 4'd5, 1'b1, 1'b1, 2'd2);

    press(2);
    do_reset();
    idle(8);
    chk_all("post_rst", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);

    // Simultaneous load and clear from S_B: clear wins.
    sw = 4'd3;
    press(10);
    idle(8);
    chk_all("to_b", 4'd3, 4'd0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 10; i++) cyc(1, 1);
    idle(8);
    chk_all("clr_win", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);

    // Switch activity without a press leaves the outputs alone.
    sw = 4'd12;
    press(10);
    idle(8);
    rnd = 1;
    idle(40);
    chk_all("sw_noise", 4'd12, 4'd0, 1'b0, 1'b0, 2'd1);

    for (int k = 0; k < 25; k++) begin
      logic ld, cl;
      int   len;
      ld  = 1'($urandom_range(0, 1));
      cl  = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 8);
      repeat (len) cyc(ld, cl);
      idle($urandom_range(0, 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
